// File: rtl/spi_osd_master.sv
// Write-only SPI master (mode 0) that frames a command byte, a 16-bit start
// address and a streamed payload into the OSD's SPI slave port.
module spi_osd_master #(
  parameter int         c_clk_div   = 4,
  parameter logic [7:0] c_cmd_write = 8'h00,
  parameter int         c_len_bits  = 12
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_start,
  input  logic [15:0]           i_addr,
  input  logic [c_len_bits-1:0] i_len,
  input  logic [7:0]            i_data,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_csn,
  output logic                  o_sclk,
  output logic                  o_mosi
);

  localparam logic [2:0] st_idle  = 3'd0;
  localparam logic [2:0] st_setup = 3'd1;
  localparam logic [2:0] st_shift = 3'd2;
  localparam logic [2:0] st_fetch = 3'd3;
  localparam logic [2:0] st_hold  = 3'd4;
  localparam logic [2:0] st_done  = 3'd5;

  localparam logic [7:0]            div_last = 8'(c_clk_div - 1);
  localparam logic [c_len_bits-1:0] len_one  = c_len_bits'(1);

  logic [2:0]            state_reg, state_next;
  logic [7:0]            div_reg, div_next;
  logic [2:0]            bit_reg, bit_next;
  logic [1:0]            hdr_reg, hdr_next;
  logic [c_len_bits-1:0] len_reg, len_next;
  logic [15:0]           addr_reg, addr_next;
  // Holds the not-yet-sent bits below the one currently on o_mosi.
  logic [6:0]            shift_reg, shift_next;
  logic                  csn_reg, csn_next;
  logic                  sclk_reg, sclk_next;
  logic                  mosi_reg, mosi_next;

  logic                  div_end;
  logic [7:0]            hdr_byte;

  assign div_end  = (div_reg == div_last);
  assign hdr_byte = (hdr_reg == 2'd2) ? addr_reg[15:8] : addr_reg[7:0];

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    hdr_next   = hdr_reg;
    len_next   = len_reg;
    addr_next  = addr_reg;
    shift_next = shift_reg;
    csn_next   = csn_reg;
    sclk_next  = sclk_reg;
    mosi_next  = mosi_reg;

    case (state_reg)
      st_idle: begin
        if (i_start) begin
          addr_next  = i_addr;
          len_next   = i_len;
          shift_next = c_cmd_write[6:0];
          mosi_next  = c_cmd_write[7];
          csn_next   = 1'b0;
          sclk_next  = 1'b0;
          div_next   = 8'd0;
          bit_next   = 3'd7;
          hdr_next   = 2'd2;
          state_next = st_setup;
        end
      end

      st_setup: begin
        if (div_end) begin
          div_next   = 8'd0;
          state_next = st_shift;
        end else begin
          div_next = div_reg + 8'd1;
        end
      end

      st_shift: begin
        if (!div_end) begin
          div_next = div_reg + 8'd1;
        end else begin
          div_next = 8'd0;
          if (!sclk_reg) begin
            sclk_next = 1'b1;
          end else begin
            sclk_next = 1'b0;
            if (bit_reg != 3'd0) begin
              bit_next   = bit_reg - 3'd1;
              mosi_next  = shift_reg[6];
              shift_next = {shift_reg[5:0], 1'b0};
            end else if (hdr_reg != 2'd0) begin
              // Address bytes follow the command without a handshake.
              hdr_next   = hdr_reg - 2'd1;
              bit_next   = 3'd7;
              mosi_next  = hdr_byte[7];
              shift_next = hdr_byte[6:0];
            end else if (len_reg != '0) begin
              state_next = st_fetch;
            end else begin
              state_next = st_hold;
            end
          end
        end
      end

      st_fetch: begin
        // SCLK stays low and MOSI keeps its last bit while the source stalls.
        if (i_data_valid) begin
          mosi_next  = i_data[7];
          shift_next = i_data[6:0];
          len_next   = len_reg - len_one;
          bit_next   = 3'd7;
          div_next   = 8'd0;
          state_next = st_shift;
        end
      end

      st_hold: begin
        if (div_end) begin
          div_next   = 8'd0;
          csn_next   = 1'b1;
          mosi_next  = 1'b0;
          state_next = st_done;
        end else begin
          div_next = div_reg + 8'd1;
        end
      end

      st_done: begin
        state_next = st_idle;
      end

      default: begin
        state_next = st_idle;
        csn_next   = 1'b1;
        sclk_next  = 1'b0;
        mosi_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= st_idle;
      div_reg   <= 8'd0;
      bit_reg   <= 3'd0;
      hdr_reg   <= 2'd0;
      len_reg   <= '0;
      addr_reg  <= 16'd0;
      shift_reg <= 7'd0;
      csn_reg   <= 1'b1;
      sclk_reg  <= 1'b0;
      mosi_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
      hdr_reg   <= hdr_next;
      len_reg   <= len_next;
      addr_reg  <= addr_next;
      shift_reg <= shift_next;
      csn_reg   <= csn_next;
      sclk_reg  <= sclk_next;
      mosi_reg  <= mosi_next;
    end
  end

  assign o_csn        = csn_reg;
  assign o_sclk       = sclk_reg;
  assign o_mosi       = mosi_reg;
  assign o_data_ready = (state_reg == st_fetch);
  assign o_busy       = (state_reg != st_idle);
  assign o_done       = (state_reg == st_done);

endmodule
